load_store_queue: RTL and testbench
===================================

// Module: load_store_queue
// PURPOSE
// Receives load/store entries from ex_stage and buffers them in program order in a C_DEPTH FIFO.
// Issues them one at a time to the data-memory port with byte lanes, and writes load results back to the register file.
// Single outstanding memory transaction; misaligned accesses are not issued and are flagged as an exception pulse.
// PARAMETERS
// C_XLEN   32  datapath width; only 32 supported (4 byte lanes)
// C_DEPTH  4   FIFO entries; power of 2, >= 2
// PORTS
// clk_i            in   1       clock
// clk_en_i         in   1       clock enable; all state frozen and handshakes ignored when low
// resetb_i         in   1       reset, asynchronous, active-low
// ex_lq_wr_i       in   1       push load entry
// ex_sq_wr_i       in   1       push store entry
// ex_funct3_i      in   3       [1:0] size 00=B 01=H 10=W; [2] unsigned load
// ex_regd_addr_i   in   5       load destination register
// ex_regs2_data_i  in   C_XLEN  store data
// ex_addr_i        in   C_XLEN  effective byte address
// ex_full_o        out  1       queue full (count==C_DEPTH)
// dmem_req_o       out  1       memory request valid
// dmem_gnt_i       in   1       request accepted this cycle
// dmem_we_o        out  1       1=store, 0=load
// dmem_be_o        out  4       byte enables
// dmem_addr_o      out  C_XLEN  word address {addr[31:2],2'b00}
// dmem_wdata_o     out  C_XLEN  lane-replicated store data
// dmem_rvalid_i    in   1       load data valid
// dmem_rdata_i     in   C_XLEN  load data (full word)
// wb_regd_wr_o     out  1       register write strobe, one cycle
// wb_regd_addr_o   out  5       register write address
// wb_regd_data_o   out  C_XLEN  extended load data
// exc_misalign_o   out  1       misaligned/illegal-size pulse, one cycle
// exc_addr_o       out  C_XLEN  faulting byte address, held until next fault
// BEHAVIOUR
// Reset: FIFO empty; FSM IDLE; all outputs 0 (ex_full_o=0).
// Push: on clk_en_i with lq or sq and !ex_full_o, write {is_store,funct3,regd,data,addr} at tail.
//   Both lq and sq high: load pushed, store ignored. Push while full: dropped, no state change.
//   Push and pop in the same cycle: count unchanged. Pointers wrap modulo C_DEPTH.
// Alignment: H needs addr[0]=0; W needs addr[1:0]=0. Size 11 is illegal.
// FSM:
//   IDLE  : if count!=0, register the head into request regs and go to REQ.
//           If the head is misaligned instead: pop it, pulse exc_misalign_o, load exc_addr_o, stay IDLE.
//   REQ   : dmem_req_o=1; addr/we/be/wdata held stable until dmem_gnt_i.
//           On gnt: pop the head. Store -> IDLE. Load -> WAIT.
//   WAIT  : dmem_req_o=0. On dmem_rvalid_i: register write-back and go to IDLE.
// Byte lanes (o = addr[1:0]):
//   B: be=4'b0001<<o, wdata={4{d[7:0]}}.
//   H: be=4'b0011<<o, wdata={2{d[15:0]}}.
//   W: be=4'hF, wdata=d.
// Load extract: shift rdata right by 8*o, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to the size.
// Write-back: wb_regd_wr_o=1 for exactly one cycle, the cycle after rvalid. Suppressed if regd==0.
// Latency: push at edge N -> IDLE sees entry N+1 -> dmem_req_o high from N+2.
// Throughput: 1 store per 2 cycles at zero-wait gnt.
// dmem_rvalid_i outside WAIT is ignored. dmem_gnt_i outside REQ is ignored.
// Reset mid-operation abandons any outstanding transaction. A late rvalid after reset is ignored.
// TESTING
// SW funct3=010 addr=0x100 data=0xDEADBEEF, gnt same cycle -> req/we=1 be=F addr=0x100 wdata=0xDEADBEEF, queue empty.
// LB addr=0x103 regd=5, rdata=0x80000000 -> wb_regd_wr_o one cycle, addr=5, data=0xFFFFFF80; LBU gives 0x00000080.
// SH addr=0x102 data=0x1234 -> be=4'b1100 wdata=0x12341234; LH addr=0x101 -> no req, exc_misalign_o pulse, exc_addr_o=0x101.
// Push 4 entries with gnt held low -> ex_full_o=1; 5th push dropped; 1 gnt -> ex_full_o=0; program order preserved.
// Reset asserted in WAIT, then rvalid -> no write-back, dmem_req_o=0, queue empty; clk_en_i=0 freezes state and outputs.

Source files
------------

// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store FIFO feeding a single-outstanding data-memory port,
// with byte-lane steering, load sign/zero extension and misalignment faults.
module load_store_queue #(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              ex_full_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  output logic              exc_misalign_o,
  output logic [C_XLEN-1:0] exc_addr_o
);

  localparam int              C_PW      = $clog2(C_DEPTH);
  localparam logic [C_PW:0]   C_FULL    = (C_PW+1)'(C_DEPTH);
  localparam logic [C_PW:0]   C_CNT_ONE = (C_PW+1)'(1);
  localparam logic [C_PW-1:0] C_PTR_ONE = C_PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state, w_stateNext;
  logic              r_fStore  [C_DEPTH];
  logic [2:0]        r_fFunct3 [C_DEPTH];
  logic [4:0]        r_fRegd   [C_DEPTH];
  logic [C_XLEN-1:0] r_fData   [C_DEPTH];
  logic [C_XLEN-1:0] r_fAddr   [C_DEPTH];
  logic [C_PW-1:0]   r_head, r_tail;
  logic [C_PW:0]     r_count;

  logic              r_we, r_uns, r_wbWr, r_exc;
  logic [3:0]        r_be;
  logic [1:0]        r_off, r_size;
  logic [4:0]        r_regd, r_wbAddr;
  logic [C_XLEN-1:0] r_addr, r_wdata, r_wbData, r_excAddr;

  logic              w_full, w_notEmpty, w_push, w_pop, w_issue, w_fault, w_wbCapture;
  logic              w_hStore, w_hMisaligned;
  logic [2:0]        w_hFunct3;
  logic [4:0]        w_hRegd;
  logic [C_XLEN-1:0] w_hData, w_hAddr, w_hWdata, w_shifted, w_ext;
  logic [3:0]        w_hBe;

  assign w_full     = (r_count == C_FULL);
  assign w_notEmpty = (r_count != '0);
  assign w_push     = clk_en_i & (ex_lq_wr_i | ex_sq_wr_i) & ~w_full;

  assign w_hStore  = r_fStore[r_head];
  assign w_hFunct3 = r_fFunct3[r_head];
  assign w_hRegd   = r_fRegd[r_head];
  assign w_hData   = r_fData[r_head];
  assign w_hAddr   = r_fAddr[r_head];

  // Size 11 is never legal; halfwords and words must sit on their natural boundary.
  always_comb begin
    w_hMisaligned = 1'b0;
    case (w_hFunct3[1:0])
      2'b01:   w_hMisaligned = w_hAddr[0];
      2'b10:   w_hMisaligned = |w_hAddr[1:0];
      2'b11:   w_hMisaligned = 1'b1;
      default: w_hMisaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_hBe    = 4'hF;
    w_hWdata = w_hData;
    case (w_hFunct3[1:0])
      2'b00: begin
        w_hBe    = 4'b0001 << w_hAddr[1:0];
        w_hWdata = {4{w_hData[7:0]}};
      end
      2'b01: begin
        w_hBe    = 4'b0011 << w_hAddr[1:0];
        w_hWdata = {2{w_hData[15:0]}};
      end
      default: begin
        w_hBe    = 4'hF;
        w_hWdata = w_hData;
      end
    endcase
  end

  assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      2'b00:   w_ext = r_uns ? {{(C_XLEN-8){1'b0}}, w_shifted[7:0]}
                             : {{(C_XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = r_uns ? {{(C_XLEN-16){1'b0}}, w_shifted[15:0]}
                             : {{(C_XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)     r_state <= S_IDLE;
    else if (clk_en_i) r_state <= w_stateNext;
  end

  // The head stays in the FIFO until the memory grants it, so ex_full_o reflects the in-flight entry.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_fault     = 1'b0;
    w_pop       = 1'b0;
    w_wbCapture = 1'b0;
    case (r_state)
      S_IDLE: if (w_notEmpty) begin
        if (w_hMisaligned) begin
          w_fault = 1'b1;
          w_pop   = 1'b1;
        end else begin
          w_issue     = 1'b1;
          w_stateNext = S_REQ;
        end
      end
      S_REQ: if (dmem_gnt_i) begin
        w_pop       = 1'b1;
        w_stateNext = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (dmem_rvalid_i) begin
        w_wbCapture = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fStore[r_tail]  <= ~ex_lq_wr_i;
      r_fFunct3[r_tail] <= ex_funct3_i;
      r_fRegd[r_tail]   <= ex_regd_addr_i;
      r_fData[r_tail]   <= ex_regs2_data_i;
      r_fAddr[r_tail]   <= ex_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clk_en_i) begin
      if (w_push) r_tail <= r_tail + C_PTR_ONE;
      if (w_pop)  r_head <= r_head + C_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_regd    <= '0;
      r_wbWr    <= 1'b0;
      r_wbAddr  <= '0;
      r_wbData  <= '0;
      r_exc     <= 1'b0;
      r_excAddr <= '0;
    end else if (clk_en_i) begin
      r_exc  <= w_fault;
      r_wbWr <= w_wbCapture && (r_regd != '0);
      if (w_fault) r_excAddr <= w_hAddr;
      if (w_issue) begin
        r_we    <= w_hStore;
        r_be    <= w_hBe;
        r_addr  <= {w_hAddr[C_XLEN-1:2], 2'b00};
        r_wdata <= w_hWdata;
        r_off   <= w_hAddr[1:0];
        r_size  <= w_hFunct3[1:0];
        r_uns   <= w_hFunct3[2];
        r_regd  <= w_hRegd;
      end
      if (w_wbCapture) begin
        r_wbAddr <= r_regd;
        r_wbData <= w_ext;
      end
    end
  end

  assign ex_full_o      = w_full;
  assign dmem_req_o     = (r_state == S_REQ);
  assign dmem_we_o      = r_we;
  assign dmem_be_o      = r_be;
  assign dmem_addr_o    = r_addr;
  assign dmem_wdata_o   = r_wdata;
  assign wb_regd_wr_o   = r_wbWr;
  assign wb_regd_addr_o = r_wbAddr;
  assign wb_regd_data_o = r_wbData;
  assign exc_misalign_o = r_exc;
  assign exc_addr_o     = r_excAddr;

endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: directed scoreboard bench for load_store_queue; expected memory requests
// and write-backs are queued when entries are pushed and checked when the DUT emits them.
module tb_load_store_queue;

  logic        clk_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        resetb_i = 1'b0;
  logic        ex_lq_wr_i = 1'b0;
  logic        ex_sq_wr_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic [4:0]  ex_regd_addr_i = '0;
  logic [31:0] ex_regs2_data_i = '0;
  logic [31:0] ex_addr_i = '0;
  logic        ex_full_o;
  logic        dmem_req_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        wb_regd_wr_o;
  logic [4:0]  wb_regd_addr_o;
  logic [31:0] wb_regd_data_o;
  logic        exc_misalign_o;
  logic [31:0] exc_addr_o;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  regd;
    logic [31:0] data;
  } wb_t;

  req_t reqQ[$];
  wb_t  wbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  load_store_queue #(.C_XLEN(32), .C_DEPTH(4)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i), .ex_funct3_i(ex_funct3_i),
    .ex_regd_addr_i(ex_regd_addr_i), .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
    .ex_full_o(ex_full_o), .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_regd_wr_o(wb_regd_wr_o), .wb_regd_addr_o(wb_regd_addr_o), .wb_regd_data_o(wb_regd_data_o),
    .exc_misalign_o(exc_misalign_o), .exc_addr_o(exc_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one entry for a single clock edge; called and returns at a negedge.
  task automatic applyStimulus(input logic lq, input logic sq, input logic [2:0] funct3,
                               input logic [4:0] regd, input logic [31:0] data, input logic [31:0] addr);
    ex_lq_wr_i      = lq;
    ex_sq_wr_i      = sq;
    ex_funct3_i     = funct3;
    ex_regd_addr_i  = regd;
    ex_regs2_data_i = data;
    ex_addr_i       = addr;
    @(negedge clk_i);
    ex_lq_wr_i = 1'b0;
    ex_sq_wr_i = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    req_t exp;
    int   waited = 0;
    while (dmem_req_o !== 1'b1 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput({tag, " req"}, 32'(dmem_req_o), 32'd1);
    exp = (reqQ.size() != 0) ? reqQ.pop_front() : '0;
    checkOutput({tag, " we"}, 32'(dmem_we_o), 32'(exp.we));
    checkOutput({tag, " be"}, 32'(dmem_be_o), 32'(exp.be));
    checkOutput({tag, " addr"}, dmem_addr_o, exp.addr);
    if (exp.we) checkOutput({tag, " wdata"}, dmem_wdata_o, exp.wdata);
  endtask

  task automatic grantReq(input string tag, input int holdCycles, input logic [31:0] expAddr);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk_i);
      checkOutput({tag, " held req"}, 32'(dmem_req_o), 32'd1);
      checkOutput({tag, " held addr"}, dmem_addr_o, expAddr);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
  endtask

  task automatic completeLoad(input string tag, input logic [31:0] rdata);
    wb_t exp;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    exp = (wbQ.size() != 0) ? wbQ.pop_front() : '0;
    if (exp.regd != 5'd0) begin
      checkOutput({tag, " wb_wr"}, 32'(wb_regd_wr_o), 32'd1);
      checkOutput({tag, " wb_addr"}, 32'(wb_regd_addr_o), 32'(exp.regd));
      checkOutput({tag, " wb_data"}, wb_regd_data_o, exp.data);
    end else begin
      checkOutput({tag, " wb_wr x0"}, 32'(wb_regd_wr_o), 32'd0);
    end
    @(negedge clk_i);
    checkOutput({tag, " wb pulse end"}, 32'(wb_regd_wr_o), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rst req", 32'(dmem_req_o), 32'd0);
    checkOutput("rst full", 32'(ex_full_o), 32'd0);
    checkOutput("rst wb_wr", 32'(wb_regd_wr_o), 32'd0);
    checkOutput("rst exc", 32'(exc_misalign_o), 32'd0);
    checkOutput("rst exc_addr", exc_addr_o, 32'd0);
    checkOutput("rst be", 32'(dmem_be_o), 32'd0);
    @(negedge clk_i);
    resetb_i = 1'b1;
    @(negedge clk_i);

    // SW with grant in the first request cycle, plus issue latency
    reqQ.push_back('{we: 1'b1, be: 4'hF, addr: 32'h100, wdata: 32'hDEADBEEF});
    applyStimulus(1'b0, 1'b1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h100);
    checkOutput("sw latency idle", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i);
    checkOutput("sw latency req", 32'(dmem_req_o), 32'd1);
    waitReq("sw");
    grantReq("sw", 0, 32'h100);
    checkOutput("sw done req", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i);
    checkOutput("sw empty req", 32'(dmem_req_o), 32'd0);

    // LB / LBU at the top byte lane
    reqQ.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h100, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd5, data: 32'hFFFFFF80});
    applyStimulus(1'b1, 1'b0, 3'b000, 5'd5, 32'h0, 32'h103);
    waitReq("lb");
    grantReq("lb", 0, 32'h100);
    completeLoad("lb", 32'h80000000);

    reqQ.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h100, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd5, data: 32'h00000080});
    applyStimulus(1'b1, 1'b0, 3'b100, 5'd5, 32'h0, 32'h103);
    waitReq("lbu");
    grantReq("lbu", 0, 32'h100);
    completeLoad("lbu", 32'h80000000);

    // SH upper half with a delayed grant
    reqQ.push_back('{we: 1'b1, be: 4'b1100, addr: 32'h100, wdata: 32'h12341234});
    applyStimulus(1'b0, 1'b1, 3'b001, 5'd0, 32'h00001234, 32'h102);
    waitReq("sh");
    grantReq("sh", 2, 32'h100);

    // LH / LHU upper half, LW to x0
    reqQ.push_back('{we: 1'b0, be: 4'b1100, addr: 32'h100, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd3, data: 32'hFFFFBEEF});
    applyStimulus(1'b1, 1'b0, 3'b001, 5'd3, 32'h0, 32'h102);
    waitReq("lh");
    grantReq("lh", 0, 32'h100);
    completeLoad("lh", 32'hBEEF1234);

    reqQ.push_back('{we: 1'b0, be: 4'b1100, addr: 32'h100, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd4, data: 32'h0000BEEF});
    applyStimulus(1'b1, 1'b0, 3'b101, 5'd4, 32'h0, 32'h102);
    waitReq("lhu");
    grantReq("lhu", 0, 32'h100);
    completeLoad("lhu", 32'hBEEF1234);

    reqQ.push_back('{we: 1'b0, be: 4'hF, addr: 32'h104, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd0, data: 32'h0});
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd0, 32'h0, 32'h104);
    waitReq("lw x0");
    grantReq("lw x0", 0, 32'h104);
    completeLoad("lw x0", 32'h11111111);

    // Misaligned LH and illegal size
    applyStimulus(1'b1, 1'b0, 3'b001, 5'd6, 32'h0, 32'h101);
    @(negedge clk_i);
    checkOutput("lh mis exc", 32'(exc_misalign_o), 32'd1);
    checkOutput("lh mis exc_addr", exc_addr_o, 32'h101);
    checkOutput("lh mis no req", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i);
    checkOutput("lh mis pulse end", 32'(exc_misalign_o), 32'd0);
    checkOutput("lh mis addr held", exc_addr_o, 32'h101);
    checkOutput("lh mis still no req", 32'(dmem_req_o), 32'd0);

    applyStimulus(1'b0, 1'b1, 3'b011, 5'd0, 32'h0, 32'h200);
    @(negedge clk_i);
    checkOutput("size11 exc", 32'(exc_misalign_o), 32'd1);
    checkOutput("size11 exc_addr", exc_addr_o, 32'h200);
    checkOutput("size11 no req", 32'(dmem_req_o), 32'd0);

    // Load and store pushed together: only the load is queued
    reqQ.push_back('{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h0});
    wbQ.push_back('{regd: 5'd7, data: 32'hCAFEF00D});
    applyStimulus(1'b1, 1'b1, 3'b010, 5'd7, 32'h55, 32'h300);
    waitReq("lq+sq");
    grantReq("lq+sq", 0, 32'h300);
    completeLoad("lq+sq", 32'hCAFEF00D);
    checkOutput("lq+sq no store", 32'(dmem_req_o), 32'd0);

    // Fill the queue with grant low, drop a fifth push, then drain in order
    for (int i = 0; i < 4; i++) begin
      reqQ.push_back('{we: 1'b1, be: 4'hF, addr: 32'h10 + 32'(4*i), wdata: 32'hA0 + 32'(i)});
      applyStimulus(1'b0, 1'b1, 3'b010, 5'd0, 32'hA0 + 32'(i), 32'h10 + 32'(4*i));
    end
    checkOutput("fill full", 32'(ex_full_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'b010, 5'd0, 32'hEE, 32'h20);
    checkOutput("drop full", 32'(ex_full_o), 32'd1);
    waitReq("fifo0");
    grantReq("fifo0", 0, 32'h10);
    checkOutput("after gnt not full", 32'(ex_full_o), 32'd0);
    waitReq("fifo1");
    grantReq("fifo1", 0, 32'h14);
    waitReq("fifo2");
    grantReq("fifo2", 0, 32'h18);
    waitReq("fifo3");
    grantReq("fifo3", 0, 32'h1C);
    repeat (3) @(negedge clk_i);
    checkOutput("fifo dropped entry absent", 32'(dmem_req_o), 32'd0);

    // Reset while waiting for load data; a late rvalid must not write back
    reqQ.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'h0});
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd9, 32'h0, 32'h400);
    waitReq("rst lw");
    grantReq("rst lw", 0, 32'h400);
    resetb_i = 1'b0;
    @(negedge clk_i);
    resetb_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    checkOutput("rst late rvalid wb", 32'(wb_regd_wr_o), 32'd0);
    checkOutput("rst req", 32'(dmem_req_o), 32'd0);
    checkOutput("rst empty", 32'(ex_full_o), 32'd0);
    @(negedge clk_i);
    checkOutput("rst late rvalid wb2", 32'(wb_regd_wr_o), 32'd0);
    checkOutput("rst no req", 32'(dmem_req_o), 32'd0);

    // Clock enable low freezes the request and ignores grant and push
    reqQ.push_back('{we: 1'b1, be: 4'b0010, addr: 32'h500, wdata: 32'h77777777});
    applyStimulus(1'b0, 1'b1, 3'b000, 5'd0, 32'h00000077, 32'h501);
    waitReq("freeze sb");
    clk_en_i        = 1'b0;
    dmem_gnt_i      = 1'b1;
    ex_sq_wr_i      = 1'b1;
    ex_funct3_i     = 3'b010;
    ex_addr_i       = 32'h600;
    ex_regs2_data_i = 32'h66;
    repeat (2) @(negedge clk_i);
    checkOutput("freeze req", 32'(dmem_req_o), 32'd1);
    checkOutput("freeze addr", dmem_addr_o, 32'h500);
    checkOutput("freeze be", 32'(dmem_be_o), 32'b0010);
    ex_sq_wr_i = 1'b0;
    dmem_gnt_i = 1'b0;
    clk_en_i   = 1'b1;
    grantReq("freeze sb", 0, 32'h500);
    repeat (3) @(negedge clk_i);
    checkOutput("freeze push ignored", 32'(dmem_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
